instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/IR owner: one memory read per control-fetch visit, with stall, redirect and timeout fault
module instruction_fetch_unit #(
   parameter int                ADDR_W      = 32,
   parameter int                INSTR_W     = 32,
   parameter int                PC_STEP     = 4,
   parameter logic [3:0]        FETCH_STATE = 4'd0,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                TIMEOUT     = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         state,
   input  logic               pc_write,
   input  logic [ADDR_W-1:0]  pc_next,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] ir,
   output logic [5:0]         opcode,
   output logic [ADDR_W-1:0]  pc,
   output logic               stall,
   output logic               fetch_fault
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
   localparam logic [7:0]        TMO  = 8'(TIMEOUT);

   logic [1:0] fsm;
   logic [7:0] wait_cnt;
   logic       fault_q;
   logic       in_fetch;
   logic       done_edge;
   logic       tmo_edge;

   assign in_fetch  = (state == FETCH_STATE);
   // Completion and timeout are only meaningful while a request is outstanding.
   assign done_edge = (fsm == S_REQ) && mem_ready;
   assign tmo_edge  = (fsm == S_REQ) && !mem_ready && ((wait_cnt + 8'd1) == TMO);

   // Fetch sequencer: issue one request per fetch visit, wait for ready or give up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm      <= S_IDLE;
         wait_cnt <= 8'd0;
         mem_addr <= '0;
         fault_q  <= 1'b0;
      end else begin
         case (fsm)
            S_IDLE: begin
               if (in_fetch && !fault_q) begin
                  fsm      <= S_REQ;
                  mem_addr <= pc;
                  wait_cnt <= 8'd0;
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  fsm <= S_DONE;
               end else if (tmo_edge) begin
                  fsm     <= S_IDLE;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DONE: begin
               // Holding here while the core sits in fetch prevents a second read.
               if (!in_fetch) fsm <= S_IDLE;
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

   // Instruction register captures read data only on the completion edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir <= '0;
      end else if (done_edge) begin
         ir <= mem_rdata;
      end
   end

   // Program counter: a redirect always beats the sequential increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (pc_write) begin
         pc <= pc_next;
      end else if (done_edge) begin
         pc <= pc + STEP;
      end
   end

   assign mem_req     = (fsm == S_REQ);
   assign stall       = (fsm == S_REQ);
   assign fetch_fault = fault_q;
   assign opcode      = ir[INSTR_W-1 -: 6];

endmodule
